l2_line_fill_sequencer: RTL and testbench

Sequences whole-cache-line transfers between the L2 cache and main memory over the word-wide memory interface. Takes one line request (fill or writeback) from the L2 controller and issues WORDS_PER_LINE single-word LOAD/STORE transactions on a memory_if requester port. It returns filled words to L2 one at a time and signals line completion. It sits directly below the L2, on the L2-to-memory path.

---
 rtl/l2_line_fill_sequencer_pkg.sv | 32 +++
 rtl/l2_line_fill_sequencer_if.sv | 24 ++
 rtl/l2_line_fill_sequencer_counter.sv | 49 ++++
 rtl/l2_line_fill_sequencer.sv | 161 ++++++++++++++++
 tb/tb_l2_line_fill_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_line_fill_sequencer_pkg.sv
// Shared types for the L2 line fill sequencer: line operations, sequencer
// states and the memory-port LOAD/STORE encoding.
package torrence_params;

    typedef enum logic [0:0] {
        LINE_FILL      = 1'b0,
        LINE_WRITEBACK = 1'b1
    } line_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } line_seq_state_e;

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        STORE = 1'b1
    } mem_op_e;

    function automatic mem_op_e line_op_to_mem_op(input line_op_e op);
        mem_op_e result;
        if (op == LINE_WRITEBACK) begin
            result = STORE;
        end else begin
            result = LOAD;
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_line_fill_sequencer_if.sv
// Word-wide main-memory port: the requester holds a transaction until the
// responder signals req_fulfilled in the same cycle.
interface memory_if
    import torrence_params::*;
#(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic [XLEN-1:0] req_address;
    mem_op_e         req_operation;
    logic [XLEN-1:0] req_store_word;
    logic            req_fulfilled;
    logic [XLEN-1:0] req_loaded_word;

    modport requester (
        output req_valid, req_address, req_operation, req_store_word,
        input  req_fulfilled, req_loaded_word
    );

    modport responder (
        input  req_valid, req_address, req_operation, req_store_word,
        output req_fulfilled, req_loaded_word
    );
endinterface

// File: rtl/l2_line_fill_sequencer_counter.sv
// Word position within a line: loads a start index and word count, advances
// with wrap-around and flags the last remaining word.
module line_word_counter #(
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [IDX_W-1:0] start_index,
    input  logic             advance,
    output logic [IDX_W-1:0] cur_index,
    output logic             last_word
);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] cur_index_q, cur_index_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;

    // Index wraps naturally because the line size is a power of two.
    always_comb begin
        cur_index_d  = cur_index_q;
        words_left_d = words_left_q;
        if (load) begin
            cur_index_d  = start_index;
            words_left_d = CNT_W'(WORDS_PER_LINE);
        end else if (advance) begin
            cur_index_d  = cur_index_q + IDX_W'(1);
            words_left_d = words_left_q - CNT_W'(1);
        end else begin
            cur_index_d  = cur_index_q;
            words_left_d = words_left_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_index_q  <= '0;
            words_left_q <= '0;
        end else begin
            cur_index_q  <= cur_index_d;
            words_left_q <= words_left_d;
        end
    end

    assign cur_index = cur_index_q;
    assign last_word = (words_left_q == CNT_W'(1));
endmodule

// File: rtl/l2_line_fill_sequencer.sv
// Splits an L2 line fill/writeback into single-word memory transactions.
// Optional L2_CRITICAL_WORD_FIRST_EN starts fills at the requested word.
module l2_line_fill_sequencer
    import torrence_params::*;
#(
    parameter int XLEN           = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W         = $clog2(WORDS_PER_LINE),
    localparam int OFF_W         = $clog2(XLEN / 8)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_req_valid,
    input  line_op_e           line_req_op,
    input  logic [XLEN-1:0]    line_req_address,
    output logic               line_req_ready,
    output logic [IDX_W-1:0]   wb_word_index,
    input  logic [XLEN-1:0]    wb_word,
    output logic               fill_word_valid,
    output logic [IDX_W-1:0]   fill_word_index,
    output logic [XLEN-1:0]    fill_word,
    output logic               line_done,
    memory_if.requester        mem_if
);
    localparam int LOW_W = IDX_W + OFF_W;
    localparam int TAG_W = XLEN - LOW_W;

    line_seq_state_e  state_q, state_d;
    line_op_e         op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             fill_word_valid_q, fill_word_valid_d;
    logic [IDX_W-1:0] fill_word_index_q, fill_word_index_d;
    logic [XLEN-1:0]  fill_word_q, fill_word_d;

    logic             ctr_load_s;
    logic             ctr_advance_s;
    logic [IDX_W-1:0] start_index_s;
    logic [IDX_W-1:0] cur_index_s;
    logic             last_word_s;
    logic             unused_addr_bits_s;

    // Byte offset (and word offset without critical-word-first) carries no meaning here.
    assign unused_addr_bits_s = ^line_req_address[LOW_W-1:0];

    line_word_counter #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .load        (ctr_load_s),
        .start_index (start_index_s),
        .advance     (ctr_advance_s),
        .cur_index   (cur_index_s),
        .last_word   (last_word_s)
    );

    // First word of the line; writebacks always start at word 0.
    always_comb begin
`ifdef L2_CRITICAL_WORD_FIRST_EN
        if (line_req_op == LINE_FILL) begin
            start_index_s = line_req_address[OFF_W +: IDX_W];
        end else begin
            start_index_s = '0;
        end
`else
        start_index_s = '0;
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        tag_d             = tag_q;
        ctr_load_s        = 1'b0;
        ctr_advance_s     = 1'b0;
        fill_word_valid_d = 1'b0;
        fill_word_index_d = fill_word_index_q;
        fill_word_d       = fill_word_q;
        case (state_q)
            ST_IDLE: begin
                if (line_req_valid) begin
                    state_d    = ST_ISSUE;
                    op_d       = line_req_op;
                    tag_d      = line_req_address[XLEN-1:LOW_W];
                    ctr_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_if.req_fulfilled) begin
                    ctr_advance_s = 1'b1;
                    if (op_q == LINE_FILL) begin
                        fill_word_valid_d = 1'b1;
                        fill_word_index_d = cur_index_s;
                        fill_word_d       = mem_if.req_loaded_word;
                    end else begin
                        fill_word_valid_d = 1'b0;
                    end
                    state_d = last_word_s ? ST_DONE : ST_GAP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_GAP:  state_d = ST_ISSUE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs and the memory transaction fields.
    always_comb begin
        line_req_ready   = 1'b0;
        mem_if.req_valid = 1'b0;
        line_done        = 1'b0;
        case (state_q)
            ST_IDLE:  line_req_ready   = 1'b1;
            ST_ISSUE: mem_if.req_valid = 1'b1;
            ST_GAP:   line_req_ready   = 1'b0;
            ST_DONE:  line_done        = 1'b1;
            default: begin
                line_req_ready   = 1'bx;
                mem_if.req_valid = 1'bx;
                line_done        = 1'bx;
            end
        endcase
        mem_if.req_address   = {tag_q, cur_index_s, {OFF_W{1'b0}}};
        mem_if.req_operation = line_op_to_mem_op(op_q);
        if (op_q == LINE_WRITEBACK) begin
            mem_if.req_store_word = wb_word;
        end else begin
            mem_if.req_store_word = '0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            op_q              <= LINE_FILL;
            tag_q             <= '0;
            fill_word_valid_q <= 1'b0;
            fill_word_index_q <= '0;
            fill_word_q       <= '0;
        end else begin
            state_q           <= state_d;
            op_q              <= op_d;
            tag_q             <= tag_d;
            fill_word_valid_q <= fill_word_valid_d;
            fill_word_index_q <= fill_word_index_d;
            fill_word_q       <= fill_word_d;
        end
    end

    assign wb_word_index   = cur_index_s;
    assign fill_word_valid = fill_word_valid_q;
    assign fill_word_index = fill_word_index_q;
    assign fill_word       = fill_word_q;
endmodule

// File: tb/tb_l2_line_fill_sequencer.sv
// Directed bench for l2_line_fill_sequencer with a latency-programmable memory model.
module tb_l2_line_fill_sequencer;
    import torrence_params::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_req_valid;
    line_op_e    line_req_op;
    logic [31:0] line_req_address;
    logic        line_req_ready;
    logic [1:0]  wb_word_index;
    logic [31:0] wb_word;
    logic        fill_word_valid;
    logic [1:0]  fill_word_index;
    logic [31:0] fill_word;
    logic        line_done;

    memory_if #(.XLEN(32)) mem_bus ();

    always #5 clk = ~clk;

    l2_line_fill_sequencer #(.XLEN(32), .WORDS_PER_LINE(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .line_req_valid   (line_req_valid),
        .line_req_op      (line_req_op),
        .line_req_address (line_req_address),
        .line_req_ready   (line_req_ready),
        .wb_word_index    (wb_word_index),
        .wb_word          (wb_word),
        .fill_word_valid  (fill_word_valid),
        .fill_word_index  (fill_word_index),
        .fill_word        (fill_word),
        .line_done        (line_done),
        .mem_if           (mem_bus)
    );

    int   lat = 0;
    logic spur = 1'b0;
    int   wait_cnt = 0;
    int   cyc = 0;
    int   unstable = 0;

    assign wb_word = 32'hB0 + {30'h0, wb_word_index};
    assign mem_bus.req_fulfilled = (mem_bus.req_valid && (wait_cnt == lat)) || (spur && !mem_bus.req_valid);
    assign mem_bus.req_loaded_word = 32'hA0 + {30'h0, mem_bus.req_address[3:2]};

    typedef struct {
        logic [31:0] addr;
        logic        op;
        logic [31:0] data;
        int          cyc;
        int          hold;
    } trans_t;
    typedef struct {
        logic [1:0]  idx;
        logic [31:0] word;
        logic        done;
    } fill_t;

    trans_t tq[$];
    fill_t  fq[$];
    int     done_q[$];
    int     acc_q[$];

    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        prev_op = 1'b0;

    // Memory model, transaction log and stability monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            wait_cnt <= 0;
        end else if (mem_bus.req_valid) begin
            if (mem_bus.req_fulfilled) begin
                tq.push_back('{mem_bus.req_address, logic'(mem_bus.req_operation),
                               mem_bus.req_store_word, cyc, wait_cnt + 1});
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
        if (fill_word_valid) fq.push_back('{fill_word_index, fill_word, line_done});
        if (line_done) done_q.push_back(cyc);
        if (line_req_valid && line_req_ready && !reset) acc_q.push_back(cyc);
        if (mem_bus.req_valid && prev_pending &&
            (mem_bus.req_address != prev_addr || mem_bus.req_store_word != prev_data ||
             logic'(mem_bus.req_operation) != prev_op))
            unstable <= unstable + 1;
        prev_pending <= mem_bus.req_valid && !mem_bus.req_fulfilled && !reset;
        prev_addr    <= mem_bus.req_address;
        prev_data    <= mem_bus.req_store_word;
        prev_op      <= logic'(mem_bus.req_operation);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tq.delete();
        fq.delete();
        done_q.delete();
        acc_q.delete();
    endtask

    task automatic send(input line_op_e op, input logic [31:0] a);
        line_req_valid   = 1'b1;
        line_req_op      = op;
        line_req_address = a;
        @(negedge clk);
        line_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (line_done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(line_done), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int ub;
        int n;
        int s;
        int e;
        reset            = 1'b1;
        line_req_valid   = 1'b0;
        line_req_op      = LINE_FILL;
        line_req_address = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_ready", 64'(line_req_ready), 64'd1);
        chk("rst_req_valid", 64'(mem_bus.req_valid), 64'd0);
        chk("rst_fill_valid", 64'(fill_word_valid), 64'd0);
        chk("rst_line_done", 64'(line_done), 64'd0);
        chk("rst_fill_word", 64'(fill_word), 64'd0);
        chk("rst_fill_index", 64'(fill_word_index), 64'd0);
        chk("rst_wb_index", 64'(wb_word_index), 64'd0);

        // Fill at 0x1000, zero-latency memory.
        clear_logs();
        lat = 0;
        send(LINE_FILL, 32'h1000);
        wait_done("fill", 40);
        chk("fill_ntrans", 64'(tq.size()), 64'd4);
        chk("fill_nstrobe", 64'(fq.size()), 64'd4);
        chk("fill_ndone", 64'(done_q.size()), 64'd1);
        if (tq.size() == 4 && fq.size() == 4 && acc_q.size() == 1 && done_q.size() == 1) begin
            chk("fill_first_latency", 64'(tq[0].cyc - acc_q[0]), 64'd1);
            for (int i = 0; i < 4; i++) begin
                chk("fill_addr", 64'(tq[i].addr), 64'(32'h1000 + 32'(4 * i)));
                chk("fill_op", 64'(tq[i].op), 64'(LOAD));
                chk("fill_idx", 64'(fq[i].idx), 64'(i));
                chk("fill_word", 64'(fq[i].word), 64'(32'hA0 + 32'(i)));
                if (i > 0) chk("fill_spacing", 64'(tq[i].cyc - tq[i-1].cyc), 64'd2);
            end
            chk("fill_done_with_last", 64'(fq[3].done), 64'd1);
            chk("fill_no_early_done", 64'(fq[2].done), 64'd0);
            chk("fill_done_cycle", 64'(done_q[0] - tq[3].cyc), 64'd1);
        end

        // Writeback at 0x2000 with 3-cycle memory latency.
        clear_logs();
        ub  = unstable;
        lat = 3;
        send(LINE_WRITEBACK, 32'h2000);
        wait_done("wb", 80);
        chk("wb_ntrans", 64'(tq.size()), 64'd4);
        chk("wb_nstrobe", 64'(fq.size()), 64'd0);
        chk("wb_ndone", 64'(done_q.size()), 64'd1);
        chk("wb_stable", 64'(unstable - ub), 64'd0);
        if (tq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("wb_addr", 64'(tq[i].addr), 64'(32'h2000 + 32'(4 * i)));
                chk("wb_op", 64'(tq[i].op), 64'(STORE));
                chk("wb_data", 64'(tq[i].data), 64'(32'hB0 + 32'(i)));
                chk("wb_hold", 64'(tq[i].hold), 64'd4);
                if (i > 0) chk("wb_spacing", 64'(tq[i].cyc - tq[i-1].cyc), 64'd5);
            end
        end

        // Fill at 0x3008: word order depends on critical-word-first.
        clear_logs();
        lat = 0;
`ifdef L2_CRITICAL_WORD_FIRST_EN
        s = 2;
`else
        s = 0;
`endif
        send(LINE_FILL, 32'h3008);
        wait_done("cwf", 40);
        chk("cwf_ntrans", 64'(tq.size()), 64'd4);
        if (tq.size() == 4 && fq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                e = (s + i) % 4;
                chk("cwf_addr", 64'(tq[i].addr), 64'(32'h3000 + 32'(4 * e)));
                chk("cwf_idx", 64'(fq[i].idx), 64'(e));
                chk("cwf_word", 64'(fq[i].word), 64'(32'hA0 + 32'(e)));
            end
        end

        // Reset while word 2 of a fill is outstanding.
        clear_logs();
        lat = 2;
        send(LINE_FILL, 32'h4000);
        n = 0;
        while (!(mem_bus.req_valid === 1'b1 && wb_word_index === 2'd2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_word2", 64'(wb_word_index), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", 64'(mem_bus.req_valid), 64'd0);
        chk("midrst_ready", 64'(line_req_ready), 64'd1);
        chk("midrst_line_done", 64'(line_done), 64'd0);
        chk("midrst_fill_valid", 64'(fill_word_valid), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 64'(done_q.size()), 64'd0);
        chk("midrst_idle_valid", 64'(mem_bus.req_valid), 64'd0);
        clear_logs();
        lat = 0;
        send(LINE_FILL, 32'h5000);
        wait_done("postrst", 40);
        chk("postrst_ntrans", 64'(tq.size()), 64'd4);
        if (tq.size() > 0) chk("postrst_first_addr", 64'(tq[0].addr), 64'h5000);
        if (fq.size() > 0) chk("postrst_first_idx", 64'(fq[0].idx), 64'd0);
        chk("postrst_ndone", 64'(done_q.size()), 64'd1);

        // Request held across two lines, spurious fulfilment outside ST_ISSUE.
        clear_logs();
        lat  = 0;
        spur = 1'b1;
        line_req_valid   = 1'b1;
        line_req_op      = LINE_FILL;
        line_req_address = 32'h6000;
        n = 0;
        while (acc_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        line_req_valid = 1'b0;
        chk("b2b_naccept", 64'(acc_q.size()), 64'd2);
        wait_done("b2b", 40);
        spur = 1'b0;
        chk("b2b_ndone", 64'(done_q.size()), 64'd2);
        chk("b2b_nstrobe", 64'(fq.size()), 64'd8);
        chk("b2b_ntrans", 64'(tq.size()), 64'd8);
        if (acc_q.size() == 2 && done_q.size() == 2)
            chk("b2b_accept_after_idle", 64'(acc_q[1] - done_q[0]), 64'd1);
        if (acc_q.size() == 2 && tq.size() == 8)
            chk("b2b_second_first_word", 64'(tq[4].cyc - acc_q[1]), 64'd1);
        if (fq.size() == 8) begin
            for (int i = 0; i < 4; i++) chk("b2b_idx", 64'(fq[4 + i].idx), 64'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
